// File: rtl/uart_tx_sequencer_if.sv
// Handshake bundle between the frame-buffer TX sequencer and its environment:
// control/status, RAM read port and UART transmitter port.
interface uart_tx_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        tx_data;
  logic              tx_wr_en;
  logic              tx_busy;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              ack_err;
  logic [ADDR_W-1:0] byte_cnt;

  modport master (
    input  start, abort, base_addr, len, mem_rdata, tx_busy,
    output mem_rd_en, mem_addr, tx_data, tx_wr_en, busy, done, aborted, ack_err, byte_cnt
  );

  modport slave (
    output start, abort, base_addr, len, mem_rdata, tx_busy,
    input  mem_rd_en, mem_addr, tx_data, tx_wr_en, busy, done, aborted, ack_err, byte_cnt
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Streams an optional sync header plus len bytes from the frame-buffer RAM into a
// UART byte transmitter, pacing on its busy flag and flagging missing acknowledges.
module uart_tx_sequencer #(
  parameter int         ADDR_W    = 16,
  parameter bit         HDR_EN    = 1'b1,
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  parameter int         ACK_TO    = 8
) (
  input  logic                clk_50m,
  input  logic                rst_n,
  uart_tx_sequencer_if.master bus
);

  localparam int               ACK_W    = $clog2(ACK_TO + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TO - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DRAIN, S_HDR, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_FIN
  } state_e;

  localparam state_e FIRST_STATE = HDR_EN ? S_HDR : S_FETCH;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] cnt_next;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic              ack_err_q, ack_err_d;
  logic              aborted_q, aborted_d;
  logic              abort_req_q, abort_req_d;
  logic              is_hdr_q, is_hdr_d;
  logic              mem_rd_en;
  logic              tx_wr_en;

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values, matching the hardware and avoiding sim races.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      ack_cnt_q   <= '0;
      ack_err_q   <= 1'b0;
      aborted_q   <= 1'b0;
      abort_req_q <= 1'b0;
      is_hdr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      ack_cnt_q   <= ack_cnt_d;
      ack_err_q   <= ack_err_d;
      aborted_q   <= aborted_d;
      abort_req_q <= abort_req_d;
      is_hdr_q    <= is_hdr_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    ack_cnt_d   = ack_cnt_q;
    ack_err_d   = ack_err_q;
    aborted_d   = aborted_q;
    abort_req_d = abort_req_q;
    is_hdr_d    = is_hdr_q;
    mem_rd_en   = 1'b0;
    tx_wr_en    = 1'b0;
    cnt_next    = is_hdr_q ? cnt_q : cnt_q + ADDR_W'(1);

    // Abort is a level that may drop before the in-flight byte finishes; remember it.
    if (state_q != S_IDLE && bus.abort) abort_req_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d      = bus.base_addr;
          len_d       = bus.len;
          cnt_d       = '0;
          ack_err_d   = 1'b0;
          aborted_d   = 1'b0;
          abort_req_d = 1'b0;
          if (!HDR_EN && bus.len == '0) state_d = S_FIN;
          else if (bus.tx_busy)         state_d = S_DRAIN;
          else                          state_d = FIRST_STATE;
        end
      end
      S_DRAIN: begin
        if (bus.abort || abort_req_q) begin
          aborted_d = 1'b1;
          state_d   = S_FIN;
        end else if (!bus.tx_busy) begin
          state_d = FIRST_STATE;
        end
      end
      S_HDR: begin
        tx_data_d = SYNC_BYTE;
        is_hdr_d  = 1'b1;
        state_d   = S_ISSUE;
      end
      S_FETCH: begin
        mem_rd_en = 1'b1;
        state_d   = S_LATCH;
      end
      S_LATCH: begin
        tx_data_d = bus.mem_rdata;
        is_hdr_d  = 1'b0;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        tx_wr_en  = 1'b1;
        ack_cnt_d = '0;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          ack_err_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          cnt_d = cnt_next;
          if (bus.abort || abort_req_q) begin
            aborted_d = 1'b1;
            state_d   = S_FIN;
          end else if (cnt_next != len_q) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_rd_en = mem_rd_en;
  assign bus.mem_addr  = base_q + cnt_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_wr_en  = tx_wr_en;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_FIN);
  assign bus.aborted   = aborted_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.byte_cnt  = cnt_q;

endmodule
